// File: rtl/register_bank_pkg.sv
// Shared definitions for the input selector and the register bank: controller state
// encoding and default bank geometry.
package register_bank_pkg;

    localparam int DATA_WIDTH_DEF  = 4;
    localparam int REGS_INPUTS_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        CLEAR = 2'd2
    } bankState_t;

endpackage

// File: rtl/register_bank_ctrl.sv
// bank_ctrl: write sequencer for the register bank (single write, burst, clear sweep).
// The clear sweep exists only when REG_BANK_CLEAR_EN is defined.
module bank_ctrl
    import register_bank_pkg::*;
#(
    parameter int REGS_INPUTS = REGS_INPUTS_DEF,
    localparam int AW = $clog2(REGS_INPUTS)
) (
    input  logic          wClk,
    input  logic          wRst_n,
    input  logic          wWrite,
    input  logic          wBurst,
    input  logic          wClear,
    input  logic [AW-1:0] wAddr,
    input  logic [AW-1:0] wLen,
    output logic          wrEn,
    output logic [AW-1:0] wrAddr,
    output logic          clrSel,
    output logic          wBusy,
    output logic          wDone,
    output bankState_t    wState
);

    // Requests are level-sampled: one is taken on an edge only while in IDLE
    // (priority clear > burst > write); anything seen while busy is dropped.
    bankState_t    state, nextState;
    logic [AW-1:0] ptr, nextPtr;
    logic [AW-1:0] rem, nextRem;
    logic          doneNext;

`ifndef REG_BANK_CLEAR_EN
    logic unusedClear;
    assign unusedClear = wClear;
`endif

    always_comb begin
        nextState = state;
        nextPtr   = ptr;
        nextRem   = rem;
        wrEn      = 1'b0;
        wrAddr    = ptr;
        clrSel    = 1'b0;
        doneNext  = 1'b0;
        case (state)
            IDLE: begin
`ifdef REG_BANK_CLEAR_EN
                if (wClear) begin
                    nextState = CLEAR;
                    nextPtr   = '0;
                end else
`endif
                if (wBurst || wWrite) begin
                    wrEn    = 1'b1;
                    wrAddr  = wAddr;
                    nextPtr = AW'(wAddr + 1'b1);
                    nextRem = wLen;
                    if (wBurst && (wLen != '0)) nextState = BURST;
                    else                        doneNext  = 1'b1;
                end
            end
            BURST: begin
                wrEn    = 1'b1;
                nextPtr = AW'(ptr + 1'b1);
                nextRem = AW'(rem - 1'b1);
                if (rem == AW'(1)) begin
                    nextState = IDLE;
                    doneNext  = 1'b1;
                end
            end
`ifdef REG_BANK_CLEAR_EN
            CLEAR: begin
                wrEn    = 1'b1;
                clrSel  = 1'b1;
                nextPtr = AW'(ptr + 1'b1);
                if (ptr == AW'(REGS_INPUTS - 1)) begin
                    nextState = IDLE;
                    doneNext  = 1'b1;
                end
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge wClk or negedge wRst_n) begin
        if (!wRst_n) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
            wBusy <= 1'b0;
            wDone <= 1'b0;
        end else begin
            state <= nextState;
            ptr   <= nextPtr;
            rem   <= nextRem;
            wBusy <= (nextState != IDLE);
            wDone <= doneNext;
        end
    end

    assign wState = state;

endmodule

// File: rtl/register_bank.sv
// register_bank: REGS_INPUTS x DATA_WIDTH storage fed by the selector, exported as a flat bus.
// Optional clear sweep enabled by defining REG_BANK_CLEAR_EN.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int REGS_INPUTS = REGS_INPUTS_DEF,
    localparam int AW = $clog2(REGS_INPUTS)
) (
    input  logic                          wClk,
    input  logic                          wRst_n,
    input  logic                          wWrite,
    input  logic                          wBurst,
    input  logic                          wClear,
    input  logic [AW-1:0]                 wAddr,
    input  logic [AW-1:0]                 wLen,
    input  logic [DATA_WIDTH-1:0]         wDataIn,
    output logic [REGS_INPUTS*DATA_WIDTH-1:0] wDataRegs,
    output logic                          wBusy,
    output logic                          wDone,
    output bankState_t                    wState
);

    logic [DATA_WIDTH-1:0] regs [REGS_INPUTS];
    logic                  wrEn;
    logic [AW-1:0]         wrAddr;
    logic                  clrSel;

    bank_ctrl #(.REGS_INPUTS(REGS_INPUTS)) uCtrl (
        .wClk   (wClk),
        .wRst_n (wRst_n),
        .wWrite (wWrite),
        .wBurst (wBurst),
        .wClear (wClear),
        .wAddr  (wAddr),
        .wLen   (wLen),
        .wrEn   (wrEn),
        .wrAddr (wrAddr),
        .clrSel (clrSel),
        .wBusy  (wBusy),
        .wDone  (wDone),
        .wState (wState)
    );

    always_ff @(posedge wClk or negedge wRst_n) begin
        if (!wRst_n) begin
            for (int k = 0; k < REGS_INPUTS; k++) regs[k] <= '0;
        end else if (wrEn) begin
            regs[wrAddr] <= clrSel ? '0 : wDataIn;
        end
    end

    // Read side is purely combinational: entry k sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
    for (genvar g = 0; g < REGS_INPUTS; g++) begin : gPack
        assign wDataRegs[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed + randomized bench for register_bank against an array model of the bank.
module tb_register_bank;
    import register_bank_pkg::*;

    localparam int DW = 4;
    localparam int NR = 64;
    localparam int AW = 6;

    logic           wClk = 1'b0;
    logic           wRst_n = 1'b1;
    logic           wWrite = 1'b0;
    logic           wBurst = 1'b0;
    logic           wClear = 1'b0;
    logic [AW-1:0]  wAddr = '0;
    logic [AW-1:0]  wLen = '0;
    logic [DW-1:0]  wDataIn = '0;
    logic [NR*DW-1:0] wDataRegs;
    logic           wBusy;
    logic           wDone;
    bankState_t     wState;

    int checkCnt = 0;
    int passCnt  = 0;
    int failCnt  = 0;
    logic [DW-1:0] model [NR];

    register_bank dut (
        .wClk      (wClk),
        .wRst_n    (wRst_n),
        .wWrite    (wWrite),
        .wBurst    (wBurst),
        .wClear    (wClear),
        .wAddr     (wAddr),
        .wLen      (wLen),
        .wDataIn   (wDataIn),
        .wDataRegs (wDataRegs),
        .wBusy     (wBusy),
        .wDone     (wDone),
        .wState    (wState)
    );

    always #5 wClk = ~wClk;

    function automatic logic [NR*DW-1:0] expBus();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int k = 0; k < NR; k++) v[k*DW +: DW] = model[k];
        return v;
    endfunction

    task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOut(input string tag, input logic expBusy, input logic expDone);
        check({tag, "/regs"}, wDataRegs, expBus());
        check({tag, "/busy"}, {{(NR*DW-1){1'b0}}, wBusy}, {{(NR*DW-1){1'b0}}, expBusy});
        check({tag, "/done"}, {{(NR*DW-1){1'b0}}, wDone}, {{(NR*DW-1){1'b0}}, expDone});
    endtask

    task automatic clearModel();
        for (int k = 0; k < NR; k++) model[k] = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wClk);
            @(negedge wClk);
            checkOut("idle", 1'b0, 1'b0);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the write.
    task automatic singleWrite(input int addr, input logic [DW-1:0] data);
        wWrite = 1'b1; wAddr = AW'(addr); wDataIn = data;
        @(posedge wClk);
        model[addr] = data;
        @(negedge wClk);
        wWrite = 1'b0;
        checkOut("write", 1'b0, 1'b1);
    endtask

    // dataMode 0: random words, 1: base+i, 2: constant base.
    task automatic burst(input int addr, input int len, input bit alsoWrite, input bit inject,
                         input int dataMode, input int base);
        logic [DW-1:0] d;
        d = (dataMode == 0) ? DW'($urandom_range(0, 15)) : DW'(base);
        wBurst = 1'b1; wWrite = alsoWrite; wAddr = AW'(addr); wLen = AW'(len); wDataIn = d;
        @(posedge wClk);
        model[addr] = d;
        for (int i = 1; i <= len; i++) begin
            @(negedge wClk);
            wBurst = 1'b0; wWrite = 1'b0;
            checkOut("burst", 1'b1, 1'b0);
            if (inject && i == 1) begin
                wWrite = 1'b1; wAddr = AW'(20);
            end
            d = (dataMode == 0) ? DW'($urandom_range(0, 15)) :
                (dataMode == 1) ? DW'(base + i) : DW'(base);
            wDataIn = d;
            @(posedge wClk);
            model[(addr + i) % NR] = d;
        end
        @(negedge wClk);
        wBurst = 1'b0; wWrite = 1'b0;
        checkOut("burstEnd", 1'b0, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] d;
        clearModel();
        #1 wRst_n = 1'b0;
        #1;
        checkOut("reset", 1'b0, 1'b0);
        check("reset/state", {{(NR*DW-2){1'b0}}, wState}, '0);
        @(negedge wClk);
        @(negedge wClk);
        wRst_n = 1'b1;
        idle(1);

        singleWrite(7, 4'hA);
        idle(1);

        burst(62, 3, 1'b0, 1'b0, 1, 10);
        idle(1);

        burst(40, 0, 1'b1, 1'b0, 0, 0);
        idle(1);
        burst(30, 4, 1'b1, 1'b0, 0, 0);

        singleWrite(20, 4'h3);
        burst(50, 6, 1'b0, 1'b1, 0, 0);
        idle(1);

        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                d = DW'($urandom_range(0, 15));
                singleWrite(int'($urandom_range(0, NR - 1)), d);
            end else begin
                burst(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 12)), 1'b0, 1'b0, 0, 0);
            end
            if ($urandom_range(0, 2) == 0) idle(1);
        end

        // Abandon a burst in its third cycle.
        d = DW'($urandom_range(0, 15));
        wBurst = 1'b1; wAddr = AW'(5); wLen = AW'(10); wDataIn = d;
        @(posedge wClk);
        model[5] = d;
        @(negedge wClk);
        wBurst = 1'b0;
        wDataIn = DW'($urandom_range(0, 15));
        @(posedge wClk);
        @(negedge wClk);
        wRst_n = 1'b0;
        clearModel();
        #1;
        checkOut("resetMid", 1'b0, 1'b0);
        @(negedge wClk);
        wRst_n = 1'b1;
        idle(3);

        burst(0, 63, 1'b0, 1'b0, 2, 15);
        idle(1);
        wClear = 1'b1;
        @(posedge wClk);
        @(negedge wClk);
        wClear = 1'b0;
`ifdef REG_BANK_CLEAR_EN
        checkOut("clearStart", 1'b1, 1'b0);
        for (int k = 0; k < NR; k++) begin
            @(posedge wClk);
            model[k] = '0;
            @(negedge wClk);
            checkOut("clear", k != NR - 1, k == NR - 1);
        end
        idle(1);
`else
        checkOut("clearOff", 1'b0, 1'b0);
        idle(3);
`endif

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/register_bank.md
# register_bank

Storage stage directly downstream of the input selector: captures the selected DATA_WIDTH word into a bank of REGS_INPUTS registers, either as a single write or as a multi-cycle burst to consecutive addresses. The bank contents are exported as the flat bus the selector reads as its register-bank input. The block drives the selector's busy bit, which keeps register data off the selector output while the bank is being rewritten.

## Interface
- DATA_WIDTH, 4, width of one register entry.
- REGS_INPUTS, 64, number of entries; power of two.
- wClk  input  1  clock; all state changes on the rising edge.
- wRst_n  input  1  reset, asynchronous, active-low.
- wWrite  input  1  single-write request, sampled in IDLE.
- wBurst  input  1  burst-write request, sampled in IDLE.
- wClear  input  1  clear-sweep request, sampled in IDLE (only with REG_BANK_CLEAR_EN).
- wAddr  input  $clog2(REGS_INPUTS)  start/target address.
- wLen  input  $clog2(REGS_INPUTS)  burst length minus one.
- wDataIn  input  DATA_WIDTH  write data (the selector output).
- wDataRegs  output  REGS_INPUTS*DATA_WIDTH  all entries; entry k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- wBusy  output  1  high while a burst or clear is in progress.
- wDone  output  1  one-cycle pulse after an operation completes.

## Operation
- States: IDLE, BURST, CLEAR.
- IDLE accepts at most one request per edge. Priority: wClear > wBurst > wWrite. Requests seen outside IDLE are ignored, not queued.
- Single write: at the accepting edge, entry[wAddr] <= wDataIn. State stays IDLE. wDone is high for the following cycle.
- Burst:
  - At the accepting edge: entry[wAddr] <= wDataIn; pointer <= wAddr+1; remaining <= wLen.
  - If wLen==0, the burst behaves exactly as a single write.
  - Otherwise the next state is BURST. Each BURST edge writes entry[pointer] <= wDataIn, increments pointer and decrements remaining.
  - The edge where remaining reaches 0 returns to IDLE, and wDone pulses in the next cycle.
- Pointer arithmetic is modulo REGS_INPUTS and wraps 63 -> 0. A burst longer than REGS_INPUTS is impossible because wLen max is REGS_INPUTS-1.
- Clear: enter CLEAR with the index at 0. Each edge zeroes entry[index]. After entry REGS_INPUTS-1 is cleared, return to IDLE and pulse wDone.
- wBusy = (state != IDLE), registered. A single write never raises wBusy.
- Reset, including mid-burst or mid-clear: all entries 0, state IDLE, wBusy 0, wDone 0. Takes effect immediately and asynchronously. The interrupted operation is abandoned and produces no wDone.

## Timing
- Write-to-visible latency: 1 cycle. A write at edge N appears on wDataRegs after edge N.
- wBusy rises after the accepting edge of a burst (wLen>0) or a clear. It falls after the final write edge.
- A burst of wLen+1 words occupies wLen+1 edges. wBusy is high for wLen cycles.
- A clear takes REGS_INPUTS edges. wBusy is high for REGS_INPUTS cycles.
- wDone is high for exactly one cycle, the cycle after the final write edge. A new request may be accepted in that same cycle.
- Read data is combinational from the registers, with no output pipeline.

## Configuration
- REG_BANK_CLEAR_EN defined: the wClear port and CLEAR state exist, with the behaviour above.
- REG_BANK_CLEAR_EN undefined: wClear is still present but ignored, the CLEAR state is not synthesized, and only reset zeroes the bank.

## Structure
- Shared package holds the state encoding constants (IDLE=2'd0, BURST=2'd1, CLEAR=2'd2) and the default DATA_WIDTH/REGS_INPUTS values, so the selector and bank agree on them.
- One sub-module, bank_ctrl, contains the FSM, pointer, remaining counter, wBusy and wDone. It outputs a write enable, write address and clear-select. The top level holds the register array and the flat-bus packing.

## Test plan
- Reset mid-burst: start a burst with wAddr=5, wLen=10, then assert wRst_n=0 on its third cycle -> all wDataRegs 0, wBusy 0 immediately, no wDone pulse.
- Single write: wWrite with wAddr=7, wDataIn=4'hA -> entry 7 reads 4'hA next cycle, wBusy stays 0, wDone pulses once.
- Burst with wrap: wBurst, wAddr=62, wLen=3, data A,B,C,D on successive cycles -> entries 62,63,0,1 = A,B,C,D; wBusy high 3 cycles; wDone pulses 1 cycle later.
- Simultaneous requests in IDLE: wWrite and wBurst together, wLen=0 -> the burst path is taken, only wAddr is written, no busy.
- Requests while busy: pulse wWrite with wAddr=20 during a burst -> entry 20 unchanged, burst completes normally.
- Clear with REG_BANK_CLEAR_EN: preload all entries to 4'hF, then pulse wClear -> wBusy high 64 cycles, entries zero in ascending order, wDone once. Without the macro -> no change.
